// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg : shared types for the calculator execution stage.
//   op_e    : command opcodes as carried on in_op
//   state_e : sequencer FSM states
// ---------------------------------------------------------------------------
package calc_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_ACC = 2'b10,
      OP_CLR = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/n_bit_adder.sv
// ---------------------------------------------------------------------------
// n_bit_adder : ripple-carry N-bit adder.
//   a, b  : N-bit addends
//   cin   : carry in
//   sum   : a + b + cin modulo 2^N
//   cout  : carry out of the MSB
//   ov    : signed overflow (carry into MSB xor carry out of MSB)
// ---------------------------------------------------------------------------
module n_bit_adder #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         ov
);

   logic [N:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < N; i++) begin : g_bit
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[N];
   assign ov   = c[N] ^ c[N-1];

endmodule

// File: rtl/calc_alu_sequencer.sv
// ---------------------------------------------------------------------------
// calc_alu_sequencer : handshaked add/sub/accumulate stage around n_bit_adder.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : command handshake (in_op, in_a, in_b)
//   out_valid/out_ready  : result handshake (out_result + flags)
//   out_cout             : adder carry (SUB: 1 = no borrow)
//   out_ov, out_zero     : signed overflow, result == 0
//   acc_value            : accumulator contents
// Optional: define CALC_SATURATE_EN to clamp overflowing results to the
// signed max/min instead of wrapping.
// ---------------------------------------------------------------------------
module calc_alu_sequencer
   import calc_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   in_op,
   input  logic [N-1:0] in_a,
   input  logic [N-1:0] in_b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_result,
   output logic         out_cout,
   output logic         out_ov,
   output logic         out_zero,
   output logic [N-1:0] acc_value
);

   state_e       state;
   op_e          op_q;
   logic [N-1:0] a_q, b_q;

   logic [N-1:0] add_a, add_b, sum, res;
   logic         add_cin, add_cout, ov;
   logic         adder_ov_unused;

   // Steer adder inputs from the captured command.
   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      case (op_q)
         OP_ADD: begin add_a = a_q;       add_b = b_q;  end
         OP_SUB: begin add_a = a_q;       add_b = ~b_q; add_cin = 1'b1; end
         OP_ACC: begin add_a = acc_value; add_b = b_q;  end
         default: ;
      endcase
   end

   n_bit_adder #(.N(N)) u_adder (
      .a    (add_a),
      .b    (add_b),
      .cin  (add_cin),
      .sum  (sum),
      .cout (add_cout),
      .ov   (adder_ov_unused)
   );

   // Overflow from the sign bits actually fed to the adder (b already
   // inverted for SUB).
   assign ov = (add_a[N-1] == add_b[N-1]) && (sum[N-1] != add_a[N-1]);

`ifdef CALC_SATURATE_EN
   localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

   // Overflow can only push away from the a-input's sign, so that sign
   // picks the rail.
   assign res = ov ? (add_a[N-1] ? SAT_MIN : SAT_MAX) : sum;
`else
   assign res = sum;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         op_q       <= OP_ADD;
         a_q        <= '0;
         b_q        <= '0;
         out_result <= '0;
         out_cout   <= 1'b0;
         out_ov     <= 1'b0;
         out_zero   <= 1'b0;
         acc_value  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  op_q     <= op_e'(in_op);
                  a_q      <= in_a;
                  b_q      <= in_b;
                  in_ready <= 1'b0;
                  state    <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (op_q == OP_CLR) begin
                  out_result <= '0;
                  out_cout   <= 1'b0;
                  out_ov     <= 1'b0;
                  out_zero   <= 1'b1;
                  acc_value  <= '0;
               end else begin
                  out_result <= res;
                  out_cout   <= add_cout;
                  out_ov     <= ov;
                  out_zero   <= (res == '0);
                  if (op_q == OP_ACC) acc_value <= res;
               end
               out_valid <= 1'b1;
               state     <= S_DONE;
            end
            S_DONE: begin
               // in_ready rises the cycle after the output handshake.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_calc_alu_sequencer.sv
module tb_calc_alu_sequencer;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   in_op;
   logic [N-1:0] in_a, in_b;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_result;
   logic         out_cout, out_ov, out_zero;
   logic [N-1:0] acc_value;

   int n_asrt = 0;
   int n_fail = 0;
   int m_acc  = 0;

   calc_alu_sequencer #(.N(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_cout   (out_cout),
      .out_ov     (out_ov),
      .out_zero   (out_zero),
      .acc_value  (acc_value)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int s8(input int x);
      return (x >= 128) ? x - 256 : x;
   endfunction

   // Reference: plain integer arithmetic on the command's meaning.
   function automatic void model(input int op, input int a, input int b,
                                 output int r, output int c, output int o, output int z);
      int s, sr;
      case (op)
         0: begin s = a + b;     c = int'(s > 255); sr = s8(a) + s8(b);     end
         1: begin s = a - b;     c = int'(a >= b);  sr = s8(a) - s8(b);     end
         2: begin s = m_acc + b; c = int'(s > 255); sr = s8(m_acc) + s8(b); end
         default: begin s = 0;   c = 0;             sr = 0;                 end
      endcase
      r = s & 255;
      o = int'(sr > 127 || sr < -128);
`ifdef CALC_SATURATE_EN
      if (o != 0) r = (sr > 127) ? 127 : 128;
`endif
      z = int'(r == 0);
      if (op == 2) m_acc = r;
      if (op == 3) m_acc = 0;
   endfunction

   task automatic run_cmd(input int op, input int a, input int b, input int hold);
      int er, ec, eo, ez;
      model(op, a, b, er, ec, eo, ez);
      chk("idle_in_ready", 32'(in_ready), 1);
      in_valid = 1'b1;
      in_op    = 2'(op);
      in_a     = N'(a);
      in_b     = N'(b);
      @(posedge clk); #1;
      // Operand changes after capture must not matter.
      in_valid = 1'b0;
      in_op    = 2'($urandom);
      in_a     = N'($urandom);
      in_b     = N'($urandom);
      chk("exec_in_ready", 32'(in_ready), 0);
      chk("exec_out_valid", 32'(out_valid), 0);
      @(posedge clk); #1;
      chk("out_valid", 32'(out_valid), 1);
      chk("result", 32'(out_result), er);
      chk("cout", 32'(out_cout), ec);
      chk("ov", 32'(out_ov), eo);
      chk("zero", 32'(out_zero), ez);
      chk("acc", 32'(acc_value), m_acc);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_out_valid", 32'(out_valid), 1);
         chk("hold_in_ready", 32'(in_ready), 0);
         chk("hold_result", 32'(out_result), er);
         chk("hold_flags", {29'd0, out_cout, out_ov, out_zero}, 32'((ec << 2) | (eo << 1) | ez));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("rel_out_valid", 32'(out_valid), 0);
      chk("rel_in_ready", 32'(in_ready), 1);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_op     = 2'd0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b0;
      #12;
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_result", 32'(out_result), 0);
      chk("rst_flags", {29'd0, out_cout, out_ov, out_zero}, 0);
      chk("rst_acc", 32'(acc_value), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases
      run_cmd(0, 8'h05, 8'h03, 0);
      run_cmd(0, 8'h7F, 8'h01, 0);
      run_cmd(1, 8'h03, 8'h05, 0);
      run_cmd(1, 8'h05, 8'h05, 0);
      run_cmd(1, 8'h80, 8'h01, 0);
      run_cmd(3, 8'hAA, 8'h55, 0);
      run_cmd(2, 8'hAA, 8'h10, 0);
      run_cmd(2, 8'h00, 8'hF0, 0);
      run_cmd(0, 8'h12, 8'h34, 5);
      run_cmd(2, 8'h00, 8'h33, 0);

      // Reset during EXEC of ACC b=0x22
      in_valid = 1'b1;
      in_op    = 2'd2;
      in_a     = 8'h00;
      in_b     = 8'h22;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n    = 1'b0;
      m_acc    = 0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 0);
      chk("arst_result", 32'(out_result), 0);
      chk("arst_flags", {29'd0, out_cout, out_ov, out_zero}, 0);
      chk("arst_acc", 32'(acc_value), 0);
      chk("arst_in_ready", 32'(in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("arst_no_valid", 32'(out_valid), 0);
      end

      // Randomized commands against the reference model
      for (int i = 0; i < 40; i++) begin
         int op, a, b;
         op = int'($urandom_range(0, 3));
         a  = int'($urandom_range(0, 255));
         b  = int'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) a = (i % 2 == 0) ? 8'h7F : 8'h80;
         run_cmd(op, a, b, int'($urandom_range(0, 2)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule

// File: doc/calc_alu_sequencer.md
Name: calc_alu_sequencer

Overview:
Handshaked execution stage wrapping the team's ripple-carry N-bit adder. It accepts one command (opcode plus two operands) over a valid/ready interface and steers the adder's a, b and cin inputs for add, subtract or accumulate. It registers sum and flags and holds the result for a downstream valid/ready consumer. It sits between the calculator's command decoder and its result/display path.

Parameters:
N, 32, datapath width in bits; legal range N >= 2.

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  reset, asynchronous and active-low
in_valid  input  1  command present
in_ready  output  1  block can accept a command
in_op  input  2  00 ADD, 01 SUB, 10 ACC, 11 CLR
in_a  input  N  operand A (ignored for ACC and CLR)
in_b  input  N  operand B (ignored for CLR)
out_valid  output  1  result and flags valid
out_ready  input  1  consumer accepts result
out_result  output  N  registered result
out_cout  output  1  adder carry-out; for SUB, 1 = no borrow
out_ov  output  1  signed two's-complement overflow
out_zero  output  1  out_result == 0
acc_value  output  N  current accumulator contents

Behaviour:
- Reset state (rst_n low, asynchronous): state=IDLE; in_ready=1; out_valid=0; out_result, out_cout, out_ov, out_zero, acc_value and operand registers all 0.
- FSM states and transitions:
  - IDLE: in_ready=1. If in_valid, capture op/a/b into registers and go to EXEC.
  - EXEC: in_ready=0. The adder evaluates combinationally from the registered operands. Result and flags are registered at the end of this cycle. Go to DONE.
  - DONE: out_valid=1. Outputs are held stable until out_valid && out_ready, then return to IDLE. No new command is accepted in the same cycle as the output handshake (in_ready goes high one cycle later).
- Latency: handshake in cycle 0, out_valid in cycle 2. Throughput is one command per 3 cycles with out_ready tied high.
- Adder steering:
  - ADD: a=A, b=B, cin=0.
  - SUB: a=A, b=~B, cin=1.
  - ACC: a=acc, b=B, cin=0; acc_value is loaded with the sum when the result is registered.
  - CLR: adder is not used; result=0, cout=0, ov=0, zero=1, acc_value=0.
- ov is computed locally from sign bits: (a_msb == b_msb_as_fed) && (sum_msb != a_msb). The adder's own ov output is left unconnected.
- Width: all arithmetic is modulo 2^N; the carry appears only on out_cout.
- in_a/in_b changes while not in IDLE have no effect.
- Reset asserted in EXEC or DONE aborts the command immediately. The result is lost and acc is cleared.
- acc_value is unchanged by ADD/SUB and changes only when an ACC/CLR result is registered.

Optional Feature:
CALC_SATURATE_EN.
- Defined: when ov=1 for ADD/SUB/ACC, out_result (and acc for ACC) clamps to the signed max 0111..1 when the sign of the a-input is 0, or to the signed min 1000..0 when it is 1. out_ov still reports 1, and out_zero is evaluated on the clamped value.
- Undefined: wrapping result; no clamp logic is synthesised.

Decomposition:
- Shared package calc_pkg holds:
  - typedef enum for opcodes (OP_ADD, OP_SUB, OP_ACC, OP_CLR);
  - typedef enum for FSM states (S_IDLE, S_EXEC, S_DONE).
- One sub-module: the existing n_bit_adder instantiated with N passed through. The FSM, steering, flags and accumulator stay in this module.

Test Plan:
- N=8, ADD a=0x05 b=0x03 -> out_valid at cycle 2; result=0x08, cout=0, ov=0, zero=0.
- N=8, ADD a=0x7F b=0x01 -> result=0x80, ov=1, cout=0; with CALC_SATURATE_EN -> result=0x7F, ov=1.
- N=8, SUB a=0x03 b=0x05 -> result=0xFE, cout=0 (borrow), ov=0; SUB a=0x05 b=0x05 -> result=0x00, cout=1, zero=1.
- N=8: CLR, then ACC b=0x10, then ACC b=0xF0 -> acc_value 0x00, 0x10, 0x00; last result has cout=1, zero=1.
- out_ready held low 5 cycles after out_valid -> out_valid and outputs remain stable and in_ready stays 0; release -> IDLE next cycle, in_ready=1.
- rst_n pulsed low during EXEC of ACC b=0x22 -> all outputs 0 asynchronously, acc_value=0, out_valid never rises for that command.
